uart_tx_engine: RTL

Line-side transmit engine of the UART: pops bytes from the TX queue through a valid/ready handshake and serialises each one onto `tx` as a start bit, 5–8 data bits (LSB first), an optional parity bit and one or two stop bits. It is driven by the TX queue and by the config register fields held in the UART register block (clock divisor, data bit count, parity type, stop bits). It is the transmit counterpart of the UART receiver.

---
 rtl/uart_tx_engine.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART line-side transmitter: pops a byte through valid/ready and serialises it as
// start, 5-8 data bits LSB first, optional parity and one or two stop bits.
module uart_tx_engine #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] clock_divisor,
   input  logic [1:0] data_bits_count,
   input  logic [1:0] parity_type,
   input  logic       double_stop_bits,
   input  logic [7:0] din,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   // Wide enough to hold OVERSAMPLE*32, the longest bit period.
   localparam int unsigned TW = $clog2(OVERSAMPLE * 32 + 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e        state_q, state_d;
   logic [7:0]    data_q, data_d;
   logic [2:0]    last_bit_q, last_bit_d;
   logic [2:0]    bit_q, bit_d;
   logic          par_en_q, par_en_d;
   logic          par_bit_q, par_bit_d;
   logic          stop2_q, stop2_d;
   logic          stop_idx_q, stop_idx_d;
   logic [TW-1:0] period_m1_q, period_m1_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [7:0]    data_mask;
   logic          par_raw;
   logic [TW-1:0] period_m1_new;
   logic          timer_last;

   always_comb begin
      unique case (data_bits_count)
         2'b00:   data_mask = 8'h1f;
         2'b01:   data_mask = 8'h3f;
         2'b10:   data_mask = 8'h7f;
         default: data_mask = 8'hff;
      endcase
   end

   // Parity only covers the bits actually sent.
   assign par_raw       = ^(din & data_mask);
   assign period_m1_new = TW'(OVERSAMPLE * (32'(clock_divisor) + 32'd1) - 32'd1);
   assign timer_last    = (timer_q == period_m1_q);

   assign ready = (state_q == StIdle);
   assign busy  = (state_q != StIdle);

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      last_bit_d  = last_bit_q;
      bit_d       = bit_q;
      par_en_d    = par_en_q;
      par_bit_d   = par_bit_q;
      stop2_d     = stop2_q;
      stop_idx_d  = stop_idx_q;
      period_m1_d = period_m1_q;
      timer_d     = timer_q;
      tx          = 1'b1;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            timer_d    = '0;
            bit_d      = '0;
            stop_idx_d = 1'b0;
            if (valid) begin
               data_d      = din;
               last_bit_d  = {1'b0, data_bits_count} + 3'd4;
               par_en_d    = ^parity_type;
               par_bit_d   = (parity_type == 2'b01) ? ~par_raw : par_raw;
               stop2_d     = double_stop_bits;
               period_m1_d = period_m1_new;
               state_d     = StStart;
            end
         end
         StStart: begin
            tx = 1'b0;
            if (timer_last) state_d = StData;
         end
         StData: begin
            tx = data_q[bit_q];
            if (timer_last) begin
               if (bit_q == last_bit_q) begin
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         StParity: begin
            tx = par_bit_q;
            if (timer_last) state_d = StStop;
         end
         StStop: begin
            if (timer_last) begin
               if (stop2_q && !stop_idx_q) begin
                  stop_idx_d = 1'b1;
               end else begin
                  done    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (state_q != StIdle) begin
         timer_d = timer_last ? '0 : timer_q + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         data_q      <= '0;
         last_bit_q  <= '0;
         bit_q       <= '0;
         par_en_q    <= 1'b0;
         par_bit_q   <= 1'b0;
         stop2_q     <= 1'b0;
         stop_idx_q  <= 1'b0;
         period_m1_q <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         last_bit_q  <= last_bit_d;
         bit_q       <= bit_d;
         par_en_q    <= par_en_d;
         par_bit_q   <= par_bit_d;
         stop2_q     <= stop2_d;
         stop_idx_q  <= stop_idx_d;
         period_m1_q <= period_m1_d;
         timer_q     <= timer_d;
      end
   end

endmodule
